cr16_alu: RTL and testbench
===========================

// Module: cr16_alu
// PURPOSE
//   16-bit CompactRISC16 ALU: arithmetic, logic, multiply and shift on two operands, plus a 5-bit status word.
//   Sits in the CR16 datapath between register-file read ports and the writeback mux.
//   Result and status are registered; the status word feeds the processor status register.
// PARAMETERS
//   none (data width fixed at 16, opcode width 4, status width 5)
// PORTS
//   I_CLK      in   1   clock, rising edge
//   I_NRESET   in   1   asynchronous, active-low reset
//   I_ENABLE   in   1   1 = capture new result/status on the next rising edge; 0 = hold
//   I_A        in   16  operand A (subtrahend for SUB/SUBU; shifted value for shifts)
//   I_B        in   16  operand B (minuend for SUB/SUBU; shift amount for shifts)
//   I_OPCODE   in   4   operation select (table below)
//   O_C        out  16  registered result
//   O_STATUS   out  5   registered flags: [0] C carry/borrow, [1] L low, [2] F overflow, [3] Z zero, [4] N negative
// BEHAVIOUR
//   - Reset (I_NRESET=0, async): O_C=16'h0000, O_STATUS=5'b00000 immediately; held until release.
//   - Latency 1 cycle: a rising edge with I_ENABLE=1 captures f(I_A,I_B,I_OPCODE); I_ENABLE=0 holds both outputs.
//   - Z = (result==0) for every opcode. Flags not listed for an opcode are 0.
//   - 0 ADD:   C=A+B mod 2^16; F=signed overflow (A15==B15 && C15!=A15); N=C[15].
//   - 1 ADDU:  C=A+B mod 2^16; C flag=bit 16 of 17-bit sum.
//   - 2 ADDC:  C=A+B+1 mod 2^16; F, N as ADD.
//   - 3 ADDCU: C=A+B+1 mod 2^16; C flag=carry out of the 17-bit sum.
//   - 4 SUB:   C=B-A mod 2^16; F=(A15!=B15 && C15!=B15); N=($signed(B)<$signed(A)).
//   - 5 SUBU:  C=B-A mod 2^16; C flag=L=(B<A unsigned).
//   - 6 MUL:   C=low 16 bits of signed A*B.
//   - 7 AND A&B; 8 OR A|B; 9 XOR A^B; 10 NOT ~A (B ignored).
//   - 11 LSH A<<B; 12 RSH A>>B (logical); 13 ALSH A<<B; 14 ARSH A>>B with sign fill.
//   - Shifts use the full 16-bit unsigned B: B==0 -> C=A; B>=16 -> C=16'h0000 for all four (incl. ARSH).
//   - 15 reserved: C=16'h0000, Z=1, other flags 0.
//   - Boundaries: 0x7FFF+1 ADD -> 0x8000, F=1, N=1; 0xFFFF+1 ADDU -> 0x0000, C=1, Z=1.
//   - Reset asserted mid-operation overrides any pending capture; first post-release enabled edge loads normally.
// STRUCTURE
//   - Shared package cr16_pkg: opcode localparams (OP_ADD..OP_ARSH, OP_RSVD=15) and status-bit indices
//     (STATUS_INDEX_CARRY=0, _LOW=1, _FLAG=2, _ZERO=3, _NEGATIVE=4).
//   - One combinational sub-module cr16_alu_core (opcode decode, 17-bit adder/subtractor, multiplier, shifter, flags)
//     wrapped by the output/status register stage in cr16_alu.
// TESTING
//   - Reset: I_NRESET=0 with nonzero operands -> O_C=0, O_STATUS=0 with no clock edge; enable=0 after release holds 0.
//   - ADD A=0x7FFF,B=0x0001 -> O_C=0x8000, O_STATUS=5'b10100; A=0x8000,B=0x8000 -> 0x0000, 5'b01100.
//   - ADDU A=0xFC00,B=0x0400 -> 0x0000, 5'b01001; ADDCU A=0xFFFF,B=0 -> 0x0000, 5'b01001.
//   - SUB A=5,B=3 -> 0xFFFE, 5'b10000; SUBU A=5,B=3 -> 0xFFFE, 5'b00011; SUBU A=B=0x1234 -> 0, 5'b01000.
//   - MUL A=0xFC00(-1024),B=0x0400 -> 0x0000; A=-3,B=7 -> 0xFFEB. NOT A=0x0400 -> 0xFBFF.
//   - Shifts A=0x8400: B=0 -> 0x8400; B=1 ARSH -> 0xC200, RSH -> 0x4200; B=0x0400 any shift -> 0x0000, Z=1.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared CR16 ALU definitions: widths, opcode encodings and status-bit positions.
package cr16_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned STATUS_W = 5;
  localparam int unsigned SHAMT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_ADDU  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADDC  = 4'd2;
  localparam logic [OP_W-1:0] OP_ADDCU = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd4;
  localparam logic [OP_W-1:0] OP_SUBU  = 4'd5;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd6;
  localparam logic [OP_W-1:0] OP_AND   = 4'd7;
  localparam logic [OP_W-1:0] OP_OR    = 4'd8;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd9;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd10;
  localparam logic [OP_W-1:0] OP_LSH   = 4'd11;
  localparam logic [OP_W-1:0] OP_RSH   = 4'd12;
  localparam logic [OP_W-1:0] OP_ALSH  = 4'd13;
  localparam logic [OP_W-1:0] OP_ARSH  = 4'd14;
  localparam logic [OP_W-1:0] OP_RSVD  = 4'd15;

  localparam int unsigned STATUS_INDEX_CARRY    = 0;
  localparam int unsigned STATUS_INDEX_LOW      = 1;
  localparam int unsigned STATUS_INDEX_FLAG     = 2;
  localparam int unsigned STATUS_INDEX_ZERO     = 3;
  localparam int unsigned STATUS_INDEX_NEGATIVE = 4;

endpackage

// File: rtl/cr16_alu_core.sv
// Combinational CR16 ALU datapath: adder/subtractor, multiplier, logic unit,
// shifter and per-opcode status flag generation.
module cr16_alu_core
  import cr16_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [OP_W-1:0]     opcode,
  output logic [DATA_W-1:0]   result_c,
  output logic [STATUS_W-1:0] status_c
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic              add_cin;
  logic [SUM_W-1:0]  add_sum;
  logic [SUM_W-1:0]  sub_diff;
  logic [DATA_W-1:0] mul_lo;
  logic              shift_oob;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0] shl;
  logic [DATA_W-1:0] shr;
  logic [DATA_W-1:0] sar;

  // One 17-bit adder serves all four add forms; bit 16 is the unsigned carry.
  assign add_cin  = (opcode == OP_ADDC) || (opcode == OP_ADDCU);
  assign add_sum  = {1'b0, a} + {1'b0, b} + SUM_W'(add_cin);
  // B - A; bit 16 is set exactly when B < A unsigned.
  assign sub_diff = {1'b0, b} - {1'b0, a};
  // The low half of a two's-complement product is sign-agnostic.
  assign mul_lo   = a * b;

  assign shift_oob = |b[DATA_W-1:SHAMT_W];
  assign shamt     = b[SHAMT_W-1:0];
  assign shl       = a << shamt;
  assign shr       = a >> shamt;
  assign sar       = $signed(a) >>> shamt;

  always_comb begin
    result_c = '0;
    status_c = '0;
    case (opcode)
      OP_ADD, OP_ADDC: begin
        result_c = add_sum[DATA_W-1:0];
        status_c[STATUS_INDEX_FLAG]     = (a[DATA_W-1] == b[DATA_W-1]) &&
                                          (result_c[DATA_W-1] != a[DATA_W-1]);
        status_c[STATUS_INDEX_NEGATIVE] = result_c[DATA_W-1];
      end
      OP_ADDU, OP_ADDCU: begin
        result_c = add_sum[DATA_W-1:0];
        status_c[STATUS_INDEX_CARRY] = add_sum[DATA_W];
      end
      OP_SUB: begin
        result_c = sub_diff[DATA_W-1:0];
        status_c[STATUS_INDEX_FLAG]     = (a[DATA_W-1] != b[DATA_W-1]) &&
                                          (result_c[DATA_W-1] != b[DATA_W-1]);
        status_c[STATUS_INDEX_NEGATIVE] = $signed(b) < $signed(a);
      end
      OP_SUBU: begin
        result_c = sub_diff[DATA_W-1:0];
        status_c[STATUS_INDEX_CARRY] = sub_diff[DATA_W];
        status_c[STATUS_INDEX_LOW]   = sub_diff[DATA_W];
      end
      OP_MUL:  result_c = mul_lo;
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_XOR:  result_c = a ^ b;
      OP_NOT:  result_c = ~a;
      // Any shift of 16 or more clears the result, arithmetic right included.
      OP_LSH, OP_ALSH: result_c = shift_oob ? '0 : shl;
      OP_RSH:  result_c = shift_oob ? '0 : shr;
      OP_ARSH: result_c = shift_oob ? '0 : sar;
      default: result_c = '0;
    endcase
    status_c[STATUS_INDEX_ZERO] = (result_c == '0);
  end

endmodule

// File: rtl/cr16_alu.sv
// CR16 ALU top: combinational core followed by the enabled result/status register.
module cr16_alu
  import cr16_pkg::*;
(
  input  logic                I_CLK,
  input  logic                I_NRESET,
  input  logic                I_ENABLE,
  input  logic [DATA_W-1:0]   I_A,
  input  logic [DATA_W-1:0]   I_B,
  input  logic [OP_W-1:0]     I_OPCODE,
  output logic [DATA_W-1:0]   O_C,
  output logic [STATUS_W-1:0] O_STATUS
);

  logic [DATA_W-1:0]   result_c;
  logic [STATUS_W-1:0] status_c;

  cr16_alu_core u_core (
    .a        (I_A),
    .b        (I_B),
    .opcode   (I_OPCODE),
    .result_c (result_c),
    .status_c (status_c)
  );

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      O_C      <= '0;
      O_STATUS <= '0;
    end else if (I_ENABLE) begin
      O_C      <= result_c;
      O_STATUS <= status_c;
    end
  end

endmodule

// File: tb/tb_cr16_alu.sv
// Self-checking bench for cr16_alu: directed corner cases plus random ops vs an integer model.
module tb_cr16_alu;
  import cr16_pkg::*;

  logic        I_CLK = 1'b0;
  logic        I_NRESET;
  logic        I_ENABLE;
  logic [15:0] I_A;
  logic [15:0] I_B;
  logic [3:0]  I_OPCODE;
  logic [15:0] O_C;
  logic [4:0]  O_STATUS;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] exp_c;
  logic [4:0]  exp_s;

  always #5 I_CLK = ~I_CLK;

  cr16_alu dut (
    .I_CLK    (I_CLK),
    .I_NRESET (I_NRESET),
    .I_ENABLE (I_ENABLE),
    .I_A      (I_A),
    .I_B      (I_B),
    .I_OPCODE (I_OPCODE),
    .O_C      (O_C),
    .O_STATUS (O_STATUS)
  );

  // Reference model in plain integer arithmetic; status = {N, Z, F, L, C}.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] op,
                                output logic [15:0] r, output logic [4:0] s);
    int sa, sb, ua, ub, full;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    r = 16'h0000;
    s = 5'b00000;
    case (op)
      OP_ADD, OP_ADDC: begin
        full = sa + sb + int'(op == OP_ADDC);
        r = 16'(full);
        s[2] = (full > 32767) || (full < -32768);
        s[4] = r[15];
      end
      OP_ADDU, OP_ADDCU: begin
        full = ua + ub + int'(op == OP_ADDCU);
        r = 16'(full);
        s[0] = full > 65535;
      end
      OP_SUB: begin
        full = sb - sa;
        r = 16'(full);
        s[2] = (full > 32767) || (full < -32768);
        s[4] = sb < sa;
      end
      OP_SUBU: begin
        r = 16'(ub - ua);
        s[0] = ub < ua;
        s[1] = ub < ua;
      end
      OP_MUL:  r = 16'(sa * sb);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_LSH, OP_ALSH: r = (ub >= 16) ? 16'h0000 : 16'(ua << ub);
      OP_RSH:  r = (ub >= 16) ? 16'h0000 : 16'(ua >> ub);
      OP_ARSH: r = (ub >= 16) ? 16'h0000 : 16'(sa >>> ub);
      default: r = 16'h0000;
    endcase
    s[3] = (r == 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [15:0] ec, input logic [4:0] es);
    n_assert++;
    assert (O_C === ec) else begin
      n_fail++;
      $error("FAIL %s result: observed %h expected %h", tag, O_C, ec);
    end
    n_assert++;
    assert (O_STATUS === es) else begin
      n_fail++;
      $error("FAIL %s status: observed %b expected %b", tag, O_STATUS, es);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic [15:0] ec, input logic [4:0] es);
    I_A      = a;
    I_B      = b;
    I_OPCODE = op;
    I_ENABLE = 1'b1;
    @(posedge I_CLK);
    #1;
    check(tag, ec, es);
  endtask

  initial begin
    I_NRESET = 1'b1;
    I_ENABLE = 1'b1;
    I_A      = 16'h7FFF;
    I_B      = 16'h0001;
    I_OPCODE = OP_ADD;

    // Async reset with nonzero operands, before any clock edge.
    #2 I_NRESET = 1'b0;
    #1 check("reset_async", 16'h0000, 5'b00000);
    repeat (2) @(posedge I_CLK);
    #1 check("reset_held", 16'h0000, 5'b00000);
    I_NRESET = 1'b1;
    I_ENABLE = 1'b0;
    @(posedge I_CLK);
    #1 check("post_reset_hold", 16'h0000, 5'b00000);

    run_op("add_ovf",    16'h7FFF, 16'h0001, OP_ADD,   16'h8000, 5'b10100);
    run_op("add_neg",    16'h8000, 16'h8000, OP_ADD,   16'h0000, 5'b01100);
    run_op("addu_carry", 16'hFC00, 16'h0400, OP_ADDU,  16'h0000, 5'b01001);
    run_op("addu_wrap",  16'hFFFF, 16'h0001, OP_ADDU,  16'h0000, 5'b01001);
    run_op("addcu",      16'hFFFF, 16'h0000, OP_ADDCU, 16'h0000, 5'b01001);
    run_op("addc",       16'h7FFE, 16'h0000, OP_ADDC,  16'h7FFF, 5'b00000);
    run_op("sub",        16'h0005, 16'h0003, OP_SUB,   16'hFFFE, 5'b10000);
    run_op("subu",       16'h0005, 16'h0003, OP_SUBU,  16'hFFFE, 5'b00011);
    run_op("subu_eq",    16'h1234, 16'h1234, OP_SUBU,  16'h0000, 5'b01000);
    run_op("mul_zero",   16'hFC00, 16'h0400, OP_MUL,   16'h0000, 5'b01000);
    run_op("mul_neg",    16'hFFFD, 16'h0007, OP_MUL,   16'hFFEB, 5'b00000);
    run_op("and",        16'hF0F0, 16'h0FF0, OP_AND,   16'h00F0, 5'b00000);
    run_op("or",         16'hF000, 16'h000F, OP_OR,    16'hF00F, 5'b00000);
    run_op("xor",        16'hAAAA, 16'hAAAA, OP_XOR,   16'h0000, 5'b01000);
    run_op("not",        16'h0400, 16'h1234, OP_NOT,   16'hFBFF, 5'b00000);
    run_op("lsh_b0",     16'h8400, 16'h0000, OP_LSH,   16'h8400, 5'b00000);
    run_op("arsh_b0",    16'h8400, 16'h0000, OP_ARSH,  16'h8400, 5'b00000);
    run_op("arsh_b1",    16'h8400, 16'h0001, OP_ARSH,  16'hC200, 5'b00000);
    run_op("rsh_b1",     16'h8400, 16'h0001, OP_RSH,   16'h4200, 5'b00000);
    run_op("lsh_b1",     16'h8400, 16'h0001, OP_LSH,   16'h0800, 5'b00000);
    run_op("lsh_big",    16'h8400, 16'h0400, OP_LSH,   16'h0000, 5'b01000);
    run_op("rsh_big",    16'h8400, 16'h0400, OP_RSH,   16'h0000, 5'b01000);
    run_op("alsh_big",   16'h8400, 16'h0400, OP_ALSH,  16'h0000, 5'b01000);
    run_op("arsh_big",   16'h8400, 16'h0400, OP_ARSH,  16'h0000, 5'b01000);
    run_op("arsh_16",    16'h8400, 16'h0010, OP_ARSH,  16'h0000, 5'b01000);
    run_op("arsh_15",    16'h8400, 16'h000F, OP_ARSH,  16'hFFFF, 5'b00000);
    run_op("rsvd",       16'h1234, 16'h5678, OP_RSVD,  16'h0000, 5'b01000);
    run_op("load_nz",    16'h7FFF, 16'h0001, OP_ADD,   16'h8000, 5'b10100);

    // Enable low holds the last capture regardless of inputs.
    I_ENABLE = 1'b0;
    I_A      = 16'h0001;
    I_B      = 16'h0001;
    I_OPCODE = OP_SUBU;
    repeat (2) @(posedge I_CLK);
    #1 check("hold", 16'h8000, 5'b10100);

    // Reset mid-cycle with a capture pending; then a normal load.
    I_ENABLE = 1'b1;
    #2 I_NRESET = 1'b0;
    #1 check("reset_mid", 16'h0000, 5'b00000);
    @(posedge I_CLK);
    #1 check("reset_mid_edge", 16'h0000, 5'b00000);
    I_NRESET = 1'b1;
    run_op("post_reset_load", 16'h0005, 16'h0003, OP_SUBU, 16'hFFFE, 5'b00011);

    exp_c = O_C;
    exp_s = O_STATUS;
    // The hold reference comes from the last directed step's known values.
    exp_c = 16'hFFFE;
    exp_s = 5'b00011;
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic        en;
      a  = 16'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 18)) : 16'($urandom);
      op = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      I_A      = a;
      I_B      = b;
      I_OPCODE = op;
      I_ENABLE = en;
      if (en) model(a, b, op, exp_c, exp_s);
      @(posedge I_CLK);
      #1 check($sformatf("rand%0d_op%0d_en%0d", i, op, en), exp_c, exp_s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
